cpu_bus_arbiter: RTL

//  Master-side controller for the cpu_if bus. Shares one cpu_if Master port between
//  NUM_REQ requesters using round-robin arbitration, and runs one access at a time.

---
 rtl/cpu_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin master-side controller sharing one cpu_if port between requesters
module cpu_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*30-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [31:0]           req_rdata,
    output logic [1:0]            req_err,
    output logic                  timeout,
    output logic                  read,
    output logic                  write,
    output logic [29:0]           address,
    output logic [31:0]           write_data,
    input  logic [31:0]           read_data,
    input  logic                  access_complete,
    input  logic                  invalid_address,
    input  logic                  invalid_access
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           err_q, err_d;
    logic                 timeout_q, timeout_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic [29:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 found;
    logic [IW-1:0]        win;
    logic [IW-1:0]        cand;

    // Round-robin pick: scan downward so the candidate closest above rr_ptr is the last one kept
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and registered-output logic for IDLE -> ACCESS -> RESP
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = 1'b0;
        read_d    = read_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d       = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    read_d       = ~req_write[win];
                    write_d      = req_write[win];
                    addr_d       = req_addr[int'(win)*30 +: 30];
                    wdata_d      = req_wdata[int'(win)*32 +: 32];
                    cnt_d        = '0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (access_complete) begin
                    done_d  = grant_q;
                    rdata_d = read_q ? read_data : 32'h0;
                    err_d   = invalid_address ? 2'b01 : invalid_access ? 2'b10 : 2'b00;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    done_d    = grant_q;
                    rdata_d   = 32'h0;
                    err_d     = 2'b11;
                    timeout_d = 1'b1;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                grant_d  = '0;
                rdata_d  = 32'h0;
                err_d    = 2'b00;
                rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset that abandons any access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            read_q    <= read_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_grant  = grant_q;
    assign req_done   = done_q;
    assign req_rdata  = rdata_q;
    assign req_err    = err_q;
    assign timeout    = timeout_q;
    assign read       = read_q;
    assign write      = write_q;
    assign address    = addr_q;
    assign write_data = wdata_q;
endmodule
